// File: rtl/imem_loader_if.sv
// ============================================================================
// imem_loader_if: host byte stream plus instruction-RAM write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader: unpacks a counted, XOR-checksummed byte frame into imem words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
  localparam int          CNT_PAD = 16 - (ADDR_W + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     count;
  logic [7:0]      hi_byte;
  logic [7:0]      checksum;
  logic            busy;
  logic            accept;
  logic            can_start;
  logic [15:0]     count_full;
  logic [ADDR_W:0] words_inc;

  assign busy       = state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
  assign bus.in_ready = busy;
  assign cpu_hold   = busy;
  assign load_done  = (state == DONE);
  assign load_err   = (state == ERROR);
  assign accept     = bus.in_valid && busy;
  assign can_start  = start && (state inside {IDLE, DONE, ERROR});
  assign count_full = {count[15:8], bus.in_data};
  assign words_inc  = words_written + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CNT_HI;
      CNT_HI:  if (accept) state_nxt = CNT_LO;
      CNT_LO:  if (accept) state_nxt = (count_full == 16'd0 || count_full > DEPTH_W) ? ERROR : DATA_HI;
      DATA_HI: if (accept) state_nxt = DATA_LO;
      DATA_LO: if (accept) state_nxt = ({{CNT_PAD{1'b0}}, words_inc} == count) ? CHECK : DATA_HI;
      CHECK:   if (accept) state_nxt = (bus.in_data == checksum) ? DONE : ERROR;
      DONE:    if (start) state_nxt = CNT_HI;
      ERROR:   if (start) state_nxt = CNT_HI;
      default: state_nxt = IDLE;
    endcase
  end

  // Word index doubles as words_written, so no separate address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= '0;
      hi_byte        <= '0;
      checksum       <= '0;
      words_written  <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (can_start) begin
        count         <= '0;
        checksum      <= '0;
        words_written <= '0;
      end
      if (accept) begin
        case (state)
          CNT_HI:  count[15:8] <= bus.in_data;
          CNT_LO:  count[7:0]  <= bus.in_data;
          DATA_HI: begin
            hi_byte  <= bus.in_data;
            checksum <= checksum ^ bus.in_data;
          end
          DATA_LO: begin
            checksum       <= checksum ^ bus.in_data;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= words_written[ADDR_W-1:0];
            bus.imem_wdata <= DATA_W'({hi_byte, bus.in_data});
            words_written  <= words_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader: random frames against a frame-level model with write scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imem_loader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            cpu_hold;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] words_written;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  typedef logic [7:0] bytes_t [$];

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  int unsigned acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (bus.in_valid && bus.in_ready) acc_cnt++;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(bus.imem_we), 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", 32'(bus.imem_wdata), 32'(e.data));
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    bit sent = 0;
    repeat ($urandom_range(0, gap)) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!sent && t < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        sent = 1;
      end
      t++;
    end
    if (!sent) check("byte_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic make_frame(input int n, input bit good, output bytes_t f);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    f = {};
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      f.push_back(b);
    end
    f.push_back(good ? x : ~x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(bus.imem_we), 0);
    check({tag, "_addr"},  32'(bus.imem_addr), 0);
    check({tag, "_wdata"}, 32'(bus.imem_wdata), 0);
    check({tag, "_hold"},  32'(cpu_hold), 0);
    check({tag, "_done"},  32'(load_done), 0);
    check({tag, "_err"},   32'(load_err), 0);
    check({tag, "_ww"},    32'(words_written), 0);
    check({tag, "_ready"}, 32'(bus.in_ready), 0);
  endtask

  // Frame-level model: count, words, XOR checksum decide writes and outcome.
  task automatic run_frame(input bytes_t f, input int gap, input bit mid_start, input string tag);
    int          n;
    int          consumed;
    bit          exp_err;
    int          ww;
    logic [7:0]  x;
    int unsigned acc0;
    n = int'({f[0], f[1]});
    if (n == 0 || n > DEPTH) begin
      consumed = 2;
      exp_err  = 1;
      ww       = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({ADDR_W'(i), f[2 + 2 * i], f[3 + 2 * i]});
        x ^= f[2 + 2 * i] ^ f[3 + 2 * i];
      end
      consumed = 3 + 2 * n;
      exp_err  = (f[2 + 2 * n] != x);
      ww       = n;
    end
    acc0 = acc_cnt;
    pulse_start();
    check({tag, "_hold_on"},  32'(cpu_hold), 1);
    check({tag, "_clr_done"}, 32'(load_done), 0);
    check({tag, "_clr_err"},  32'(load_err), 0);
    check({tag, "_clr_ww"},   32'(words_written), 0);
    for (int i = 0; i < consumed; i++) begin
      if (mid_start && i == consumed / 2) pulse_start();
      send_byte(f[i], gap);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done"},     32'(load_done), 32'(!exp_err));
    check({tag, "_err"},      32'(load_err), 32'(exp_err));
    check({tag, "_ww"},       32'(words_written), 32'(ww));
    check({tag, "_hold_off"}, 32'(cpu_hold), 0);
    check({tag, "_ready"},    32'(bus.in_ready), 0);
    check({tag, "_consumed"}, acc_cnt - acc0, 32'(consumed));
    check({tag, "_pending"},  32'(exp_q.size()), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bytes_t f;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame(f, 0, 0, "two_words");
    f[6] = 8'h00;
    run_frame(f, 2, 0, "bad_chk");

    make_frame(0, 1, f);
    run_frame(f, 1, 0, "cnt_zero");
    make_frame(513, 1, f);
    run_frame(f, 1, 0, "cnt_over");

    make_frame(512, 1, f);
    run_frame(f, 0, 0, "full_depth");

    make_frame(20, 1, f);
    run_frame(f, 3, 1, "gaps_start");
    for (int k = 0; k < 6; k++) begin
      make_frame($urandom_range(1, 40), 1'($urandom_range(0, 1)), f);
      run_frame(f, 3, 1'($urandom_range(0, 1)), "random");
    end

    make_frame(5, 1, f);
    for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(i), f[2 + 2 * i], f[3 + 2 * i]});
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(f[i], 1);
    @(negedge clk);
    @(negedge clk);
    check("abort_pending", 32'(exp_q.size()), 0);
    check("abort_ww", 32'(words_written), 3);
    #2 reset = 1'b1;
    #1 check_zero("abort");
    @(posedge clk); #1 reset = 1'b0;
    make_frame(5, 1, f);
    run_frame(f, 1, 0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
